// File: rtl/piso_mux_serializer_pkg.sv
// Shared types and constants for the PISO serializer that feeds the 8:1 bit mux.
// Also holds the helpers that pick the select start and end points for the bit order.
package piso_ser_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
  localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // The select runs from the first bit sent to the last bit sent. Which end is first depends on the bit order.
  function automatic logic [SEL_W-1:0] sel_start_f(input bit lsb_first);
    return lsb_first ? SEL_LO : SEL_HI;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end_f(input bit lsb_first);
    return lsb_first ? SEL_HI : SEL_LO;
  endfunction

endpackage

// File: rtl/piso_mux_serializer_mux8x1.sv
// Team 8:1 bit mux. Y is the bit of I that SEL selects.
// It is purely combinational.
module mux8x1 (
  input  logic [7:0] I,
  input  logic [2:0] SEL,
  output logic       Y
);

  assign Y = I[SEL];

endmodule

// File: rtl/piso_mux_serializer.sv
// Parallel-in/serial-out stage. It has a one-word pending buffer. It sequences the mux select so
// that back-to-back words leave as a gapless bit stream.
module piso_mux_serializer
  import piso_ser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] DIN,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  output logic              SOUT,
  output logic              SOUT_VALID,
  input  logic              SOUT_READY,
  output logic              FIRST,
  output logic              LAST,
  output logic [SEL_W-1:0]  BIT_IDX,
  output logic              BUSY
);

  localparam logic [SEL_W-1:0] SEL_START = sel_start_f(LSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_END   = sel_end_f(LSB_FIRST);

  state_e            state, state_nxt;
  logic [WORD_W-1:0] act_word, act_word_nxt;
  logic [WORD_W-1:0] pend_word, pend_word_nxt;
  logic              pend_full, pend_full_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;

  logic shifting, at_last, load_xfer, beat, mux_y;

  assign shifting  = (state == ST_SHIFT);
  assign at_last   = shifting && (sel == SEL_END);
  assign load_xfer = LOAD_VALID && !pend_full;
  assign beat      = shifting && SOUT_READY;

  mux8x1 u_mux (
    .I   (act_word),
    .SEL (sel),
    .Y   (mux_y)
  );

  // NOTE: every next-state variable gets a hold default first, so no path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    act_word_nxt  = act_word;
    pend_word_nxt = pend_word;
    pend_full_nxt = pend_full;
    sel_nxt       = sel;

    unique case (state)
      ST_IDLE: begin
        if (load_xfer) begin
          act_word_nxt = DIN;
          sel_nxt      = SEL_START;
          state_nxt    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (beat && !at_last) begin
          sel_nxt = LSB_FIRST ? sel + 3'd1 : sel - 3'd1;
        end else if (beat && pend_full) begin
          act_word_nxt  = pend_word;
          pend_full_nxt = 1'b0;
          sel_nxt       = SEL_START;
        end else if (beat && load_xfer) begin
          // A load on the last beat with the buffer empty goes straight to the active word, with no bubble.
          act_word_nxt = DIN;
          sel_nxt      = SEL_START;
        end else if (beat) begin
          state_nxt = ST_IDLE;
        end

        if (load_xfer && !(beat && at_last)) begin
          pend_word_nxt = DIN;
          pend_full_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: use non-blocking assignments for all state. Every flop then samples the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      act_word  <= '0;
      pend_word <= '0;
      pend_full <= 1'b0;
      sel       <= '0;
    end else begin
      state     <= state_nxt;
      act_word  <= act_word_nxt;
      pend_word <= pend_word_nxt;
      pend_full <= pend_full_nxt;
      sel       <= sel_nxt;
    end
  end

  // All outputs decode registered state only. Neither handshake input reaches an output combinationally.
  assign LOAD_READY = !pend_full;
  assign SOUT       = shifting & mux_y;
  assign SOUT_VALID = shifting;
  assign FIRST      = shifting && (sel == SEL_START);
  assign LAST       = at_last;
  assign BIT_IDX    = sel;
  assign BUSY       = shifting || pend_full;

endmodule

// File: doc/piso_mux_serializer.md
# piso_mux_serializer

Parallel-in/serial-out stage that accepts 8-bit words over a valid/ready handshake and emits them one bit per accepted beat. It drives a 3-bit bit-select counter into a combinational 8:1 mux (`I` = held word, `SEL` = counter, `Y` = serial bit). It sits directly upstream of the serial link and owns the select sequencing the mux needs. A one-word pending buffer allows back-to-back words with no idle bit slots.

## Interface
- `LSB_FIRST`, default 1: 1 emits bit 0 first (SEL 0→7); 0 emits bit 7 first (SEL 7→0).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `DIN` in 8: parallel word.
- `LOAD_VALID` in 1: `DIN` is valid.
- `LOAD_READY` out 1: equals `!pend_full`; a word transfers when `LOAD_VALID && LOAD_READY`.
- `SOUT` out 1: current serial bit, the mux output.
- `SOUT_VALID` out 1: high while in SHIFT.
- `SOUT_READY` in 1: downstream accepts the bit; a beat transfers when `SOUT_VALID && SOUT_READY`.
- `FIRST` out 1: current bit is the first bit of its word.
- `LAST` out 1: current bit is the last bit of its word.
- `BIT_IDX` out 3: current mux `SEL` value.
- `BUSY` out 1: in SHIFT, or `pend_full`.

## Operation
- Registers: `act_word[7:0]`, `pend_word[7:0]`, `pend_full`, `sel[2:0]`, and state ∈ {IDLE, SHIFT}.
- Reset values:
  - state = IDLE; `act_word`, `pend_word`, `sel` = 0; `pend_full` = 0.
  - Outputs during reset: `SOUT_VALID`/`FIRST`/`LAST`/`BUSY` = 0, `SOUT` = 0, `BIT_IDX` = 0, `LOAD_READY` = 1.
- Definitions: `sel_start` = LSB_FIRST ? 0 : 7; `sel_end` = LSB_FIRST ? 7 : 0.
- `FIRST` = SHIFT && (sel == sel_start). `LAST` = SHIFT && (sel == sel_end).
- `SOUT` = `act_word[sel]` via the mux; forced to 0 in IDLE.
- IDLE:
  - On a load transfer: `act_word` ← DIN, `sel` ← sel_start, go to SHIFT.
  - The pending buffer is never written from IDLE.
- SHIFT, per beat transfer:
  - Not LAST: `sel` steps ±1 toward sel_end.
  - LAST with `pend_full`: `act_word` ← pend_word, `pend_full` ← 0, `sel` ← sel_start, stay in SHIFT.
  - LAST, pend empty, with a load transfer in the same cycle: bypass, `act_word` ← DIN, `sel` ← sel_start, stay in SHIFT.
  - LAST, pend empty, no load: go to IDLE.
- SHIFT, load transfer without a LAST beat: `pend_word` ← DIN, `pend_full` ← 1.
- Simultaneous LAST beat and load while `pend_full`: cannot occur, because `LOAD_READY` is 0.
- Stall (`SOUT_READY` = 0): `SOUT`, `sel`, and all flags hold; `SOUT` must be stable while valid and unaccepted.
- `sel` arithmetic is 3-bit. No wrap-around past sel_end is permitted; the reload to sel_start is explicit.
- Reset asserted mid-word: the word in flight and the pending word are discarded and all outputs go to their reset values immediately, with no clock needed.

## Timing
- Load-to-first-bit latency: a load transfer at edge k gives `SOUT_VALID` = 1 and `FIRST` = 1 in the cycle after edge k.
- With `SOUT_READY` held at 1: exactly 8 cycles per word.
- Back-to-back words: a continuous bit stream (`LAST` beat followed by `FIRST` beat, no gap), provided each next word is loaded before the current `LAST` beat.
- `LOAD_READY` drops the cycle after the pending buffer fills, and rises the cycle after the pending word moves to active.
- `SOUT`, `FIRST`, `LAST`, `BIT_IDX` are combinational from registers only. There is no combinational path from `SOUT_READY` or `LOAD_VALID` to any output.

## Structure
- Package `piso_ser_pkg`:
  - `WORD_W` = 8, `SEL_W` = 3.
  - State enum {ST_IDLE, ST_SHIFT}.
  - Constant for `sel_start`/`sel_end` selection.
- Sub-module: the team's existing `mux8x1` (ports `I`, `SEL`, `Y`), instantiated with `I` = act_word, `SEL` = sel, `Y` → `SOUT` before IDLE gating.
- Remaining logic: the FSM and counter in a single always block with async reset, plus continuous assigns for the flags.

## Test plan
- Single word, LSB_FIRST = 1: load 8'b1011_0010 with `SOUT_READY` = 1 → SOUT = 0,1,0,0,1,1,0,1 over 8 consecutive cycles; FIRST on beat 0, LAST on beat 7; then IDLE with SOUT_VALID = 0.
- MSB-first: LSB_FIRST = 0, load 8'h81 → BIT_IDX = 7..0; SOUT = 1,0,0,0,0,0,0,1.
- Back-to-back: load 8'hA5, then 8'h3C two cycles later → 16 contiguous valid beats with no gap; LOAD_READY = 0 from the cycle after the second load until the cycle after the first word's LAST beat.
- Bypass: pend empty, a load of 8'hFF coincides with the LAST beat of 8'h00 → next cycle FIRST = 1, SOUT = 1, pend_full stays 0.
- Backpressure: `SOUT_READY` = 0 for 5 cycles at BIT_IDX = 3 → SOUT and BIT_IDX frozen for those 5 cycles; the stream resumes at index 3, with no bit lost or repeated.
- Reset mid-word: `rst_n` low at beat 4, asynchronous to `clk` → SOUT_VALID = 0, BUSY = 0, LOAD_READY = 1 immediately; after release, a new load of 8'h0F serializes correctly from bit 0.
